// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/ALU encodings plus instruction prefetch types.
package mips_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pf_state_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with flush; used for fetched words and pending pcs.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Flush drops contents but leaves stored words in place
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: credit-limited memory reads into a small buffer, flush on redirect.
module instr_prefetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    pf_state_e    state_q, state_d;
    logic [31:0]  next_pc_q, next_pc_d;
    fetch_entry_t last_q, last_d;

    fetch_entry_t head_entry, push_entry, view;
    logic [CW-1:0] count, outstanding, out_after;
    logic [CW:0]   credits;
    logic [31:0]   pend_pc;
    logic          accept, push, pop;
    logic          data_full, data_empty, pend_full, pend_empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_data_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count),
        .full      (data_full),
        .empty     (data_empty)
    );

    // Pending queue is never flushed: stale responses must still retire in order
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_pend_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (1'b0),
        .push      (accept),
        .push_data (next_pc_q),
        .pop       (mem_rvalid),
        .head      (pend_pc),
        .count     (outstanding),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_after = outstanding - CW'(mem_rvalid);

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = (out_after != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH && mem_rvalid && out_after == '0) begin
            state_d = RUN;
        end
    end

    always_comb begin
        credits     = {1'b0, count} + {1'b0, outstanding};
        mem_req     = reset & (state_q == RUN) & ~redirect & (credits < DEPTH_W);
        accept      = mem_req & mem_gnt;
        fetch_valid = ~data_empty & (state_q == RUN);
        pop         = fetch_valid & fetch_ready & ~redirect;
        push        = (state_q == RUN) & mem_rvalid & ~redirect;
        push_entry  = '{pc: pend_pc, instr: mem_rdata};
        view        = data_empty ? last_q : head_entry;
        fetch_pc    = view.pc;
        fetch_instr = view.instr;
        mem_addr    = next_pc_q;
    end

    always_comb begin
        next_pc_d = next_pc_q;
        if (redirect) begin
            next_pc_d = word_align(redirect_pc);
        end else if (accept) begin
            next_pc_d = next_pc_q + PC_STEP;
        end
        last_d = view;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_pc_q <= PC_INIT;
            last_q    <= '0;
        end else begin
            next_pc_q <= next_pc_d;
            last_q    <= last_d;
        end
    end

`ifndef SYNTHESIS
    a_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && data_full));
    a_rvalid_idle: assert property (@(posedge clk) disable iff (!reset)
        !(mem_rvalid && pend_empty));
    a_pend_over: assert property (@(posedge clk) disable iff (!reset)
        !(accept && pend_full));
`endif

endmodule
